// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified memory port arbiter.
package mem_arb_pkg;

  // Arbiter sequencing states; one transaction walks IDLE -> ISSUE -> WAIT -> RESP
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arbState_t;

  // Which requester currently owns the memory port
  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gntOwner_t;

  // Default memory-mapped I/O addresses of the processor's output and input ports
  localparam logic [31:0] DEFAULT_IO_OUT_ADDR = 32'h1001_0024;
  localparam logic [31:0] DEFAULT_IO_IN_ADDR  = 32'h1001_0028;

  // Width of the starvation counter; large enough for the largest legal limit (15)
  localparam int STARVE_CNT_W = 4;

  // Width of the memory latency counter; large enough for the largest legal latency (7)
  localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: counts consecutive arbitrations the fetch stage has lost
// to the load/store stage and flags when fetch must be given the next grant.
module arb_starve_counter
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int WIDTH = STARVE_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic atLimit
);

  logic [WIDTH-1:0] count;

  // Saturating counter; a clear always wins over an increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !atLimit) begin
      count <= count + WIDTH'(1);
    end
  end

  assign atLimit = (count == WIDTH'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the fetch
// stage and the load/store stage using a req/ack handshake on each side.
// Data accesses win arbitration unless fetch has starved for STARVE_LIMIT grants.
// Define MEM_ARB_IO_PORT_EN to add the memory-mapped output/input port bypass.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4,
  parameter logic [ADDR_WIDTH-1:0] IO_OUT_ADDR = ADDR_WIDTH'(DEFAULT_IO_OUT_ADDR),
  parameter logic [ADDR_WIDTH-1:0] IO_IN_ADDR  = ADDR_WIDTH'(DEFAULT_IO_IN_ADDR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_IO_PORT_EN
  ,
  input  logic [7:0]            port_in,
  output logic [DATA_WIDTH-1:0] port_out
`endif
);

  localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(MEM_LATENCY - 1);

  arbState_t              state;
  gntOwner_t              gntOwner;
  logic                   reqWe;
  logic [LAT_CNT_W-1:0]   latCnt;
  logic                   atLimit;
  logic                   grantData;
  logic                   grantFetch;
  logic                   starveInc;
  logic                   starveClr;
  logic                   ioStoreHit;
  logic                   ioLoadHit;
  logic [DATA_WIDTH-1:0]  ioLoadData;

  // Grant decision: data first, except when fetch has lost too many times in a row
  always_comb begin
    grantData  = 1'b0;
    grantFetch = 1'b0;
    if (state == IDLE) begin
      grantData  = d_req && !(if_req && atLimit);
      grantFetch = if_req && !grantData;
    end
  end

  // Starvation bookkeeping only happens while arbitrating in IDLE
  always_comb begin
    starveInc = 1'b0;
    starveClr = 1'b0;
    if (state == IDLE) begin
      starveInc = grantData && if_req;
      starveClr = !if_req || grantFetch;
    end
  end

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .WIDTH (STARVE_CNT_W)
  ) uStarve (
    .clk     (clk),
    .reset   (reset),
    .inc     (starveInc),
    .clr     (starveClr),
    .atLimit (atLimit)
  );

`ifdef MEM_ARB_IO_PORT_EN
  // Output-port stores and input-port loads never touch the memory array
  assign ioStoreHit = d_we && (d_addr == IO_OUT_ADDR);
  assign ioLoadHit  = !d_we && (d_addr == IO_IN_ADDR);
  assign ioLoadData = {{(DATA_WIDTH-8){1'b0}}, port_in};

  // Output-port register is written directly at the grant edge of an I/O store
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out <= '0;
    end else if (grantData && ioStoreHit) begin
      port_out <= d_wdata;
    end
  end
`else
  logic unusedIoCfg;
  assign ioStoreHit  = 1'b0;
  assign ioLoadHit   = 1'b0;
  assign ioLoadData  = '0;
  assign unusedIoCfg = ^{IO_OUT_ADDR, IO_IN_ADDR};
`endif

  // Transaction sequencer; every memory-side and requester-side output is registered here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gntOwner  <= GNT_IF;
      reqWe     <= 1'b0;
      latCnt    <= '0;
      if_ack    <= 1'b0;
      if_rdata  <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grantData) begin
            gntOwner <= GNT_D;
            reqWe    <= d_we;
            if (ioStoreHit || ioLoadHit) begin
              if (ioLoadHit) begin
                d_rdata <= ioLoadData;
              end
              d_ack <= 1'b1;
              state <= RESP;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              state     <= ISSUE;
            end
          end else if (grantFetch) begin
            gntOwner  <= GNT_IF;
            reqWe     <= 1'b0;
            mem_en    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          latCnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          latCnt <= latCnt + LAT_CNT_W'(1);
          if (latCnt == LAT_LAST) begin
            if (gntOwner == GNT_D) begin
              if (!reqWe) begin
                d_rdata <= mem_rdata;
              end
              d_ack <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if_ack <= 1'b0;
          d_ack  <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.
// dutA runs with MEM_LATENCY=1, dutB with MEM_LATENCY=3; both share one memory model.
// Define MEM_ARB_IO_PORT_EN to also exercise the memory-mapped I/O bypass.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam logic [31:0] POISON = 32'hBAD0_BAD0;

  typedef struct {
    bit          isData;
    logic [31:0] data;
    int          ackCyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t sbA[$];
  exp_t sbB[$];

  logic [31:0] memArr [logic [31:0]];

  // dutA signals
  logic        ifReq = 1'b0, ifAck, dReq = 1'b0, dWe = 1'b0, dAck, memEn, memWe;
  logic [31:0] ifAddr = '0, ifRdata, dAddr = '0, dWdata = '0, dRdata;
  logic [31:0] memAddr, memWdata, memRdata;
  // dutB signals
  logic        bIfReq = 1'b0, bIfAck, bDReq = 1'b0, bDWe = 1'b0, bDAck, bMemEn, bMemWe;
  logic [31:0] bIfAddr = '0, bIfRdata, bDAddr = '0, bDWdata = '0, bDRdata;
  logic [31:0] bMemAddr, bMemWdata, bMemRdata;
`ifdef MEM_ARB_IO_PORT_EN
  logic [7:0]  portIn = 8'h00;
  logic [31:0] portOut, bPortOut;
`endif

  int memEnCntA = 0, memEnCntB = 0, memWeCntB = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  mem_port_arbiter #(.MEM_LATENCY(LAT_A), .STARVE_LIMIT(4)) dutA (
    .clk(clk), .reset(reset),
    .if_req(ifReq), .if_addr(ifAddr), .if_ack(ifAck), .if_rdata(ifRdata),
    .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
    .d_ack(dAck), .d_rdata(dRdata),
    .mem_en(memEn), .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata)
`ifdef MEM_ARB_IO_PORT_EN
    , .port_in(portIn), .port_out(portOut)
`endif
  );

  mem_port_arbiter #(.MEM_LATENCY(LAT_B), .STARVE_LIMIT(4)) dutB (
    .clk(clk), .reset(reset),
    .if_req(bIfReq), .if_addr(bIfAddr), .if_ack(bIfAck), .if_rdata(bIfRdata),
    .d_req(bDReq), .d_we(bDWe), .d_addr(bDAddr), .d_wdata(bDWdata),
    .d_ack(bDAck), .d_rdata(bDRdata),
    .mem_en(bMemEn), .mem_we(bMemWe), .mem_addr(bMemAddr), .mem_wdata(bMemWdata),
    .mem_rdata(bMemRdata)
`ifdef MEM_ARB_IO_PORT_EN
    , .port_in(portIn), .port_out(bPortOut)
`endif
  );

  function automatic logic [31:0] readMem(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : 32'h0;
  endfunction

  // Memory model for dutA: reads land MEM_LATENCY cycles after the mem_en cycle
  logic [31:0] pipeA [LAT_A];
  always @(posedge clk) begin
    if (memEn === 1'b1) memEnCntA++;
    if (memEn === 1'b1 && memWe === 1'b1) memArr[memAddr] = memWdata;
    pipeA[0] <= (memEn === 1'b1 && memWe !== 1'b1) ? readMem(memAddr) : POISON;
    for (int i = LAT_A - 1; i > 0; i--) pipeA[i] <= pipeA[i-1];
  end
  assign memRdata = pipeA[LAT_A-1];

  // Memory model for dutB
  logic [31:0] pipeB [LAT_B];
  always @(posedge clk) begin
    if (bMemEn === 1'b1) memEnCntB++;
    if (bMemEn === 1'b1 && bMemWe === 1'b1) begin
      memWeCntB++;
      memArr[bMemAddr] = bMemWdata;
    end
    pipeB[0] <= (bMemEn === 1'b1 && bMemWe !== 1'b1) ? readMem(bMemAddr) : POISON;
    for (int i = LAT_B - 1; i > 0; i--) pipeB[i] <= pipeB[i-1];
  end
  assign bMemRdata = pipeB[LAT_B-1];

  task automatic test_reset();
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({memEn, memWe, ifAck, dAck} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_ctrl_a: got en/we/ifack/dack=%b expected 0000", {memEn, memWe, ifAck, dAck});
    end
    total++;
    if (ifRdata !== 32'h0 || dRdata !== 32'h0 || memAddr !== 32'h0 || memWdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_data_a: got if_rdata=%h d_rdata=%h mem_addr=%h expected all 0", ifRdata, dRdata, memAddr);
    end
    total++;
    if ({bMemEn, bIfAck, bDAck} !== 3'b000 || bDRdata !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_b: got en/ifack/dack=%b d_rdata=%h expected 000 and 0", {bMemEn, bIfAck, bDAck}, bDRdata);
    end
`ifdef MEM_ARB_IO_PORT_EN
    total++;
    if (portOut !== 32'h0) begin
      bad++; $display("[TB] FAIL reset_port_out: got %h expected 00000000", portOut);
    end
`endif
    reset = 1'b1;
  endtask

  task automatic test_single_fetch();
    exp_t e;
    int c0;
    bit seen = 0;
    @(negedge clk);
    c0 = cyc;
    ifReq = 1'b1; ifAddr = 32'h0040_0000;
    sbA.push_back(exp_t'{1'b0, 32'h2008_0005, c0 + 2 + LAT_A});
    @(negedge clk);
    total++;
    if (memEn !== 1'b1 || memWe !== 1'b0 || memAddr !== 32'h0040_0000) begin
      bad++; $display("[TB] FAIL fetch_issue: got en=%b we=%b addr=%h expected en=1 we=0 addr=00400000", memEn, memWe, memAddr);
    end
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (ifAck === 1'b1 || dAck === 1'b1) begin
        seen = 1;
        e = sbA.pop_front();
        ifReq = 1'b0;
        total++;
        if (ifAck !== 1'b1 || dAck !== 1'b0) begin
          bad++; $display("[TB] FAIL fetch_owner: got if_ack=%b d_ack=%b expected 1/0", ifAck, dAck);
        end
        total++;
        if (cyc != e.ackCyc) begin
          bad++; $display("[TB] FAIL fetch_ack_cycle: got %0d expected %0d", cyc - c0, e.ackCyc - c0);
        end
        total++;
        if (ifRdata !== e.data) begin
          bad++; $display("[TB] FAIL fetch_rdata: got %h expected %h", ifRdata, e.data);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL fetch_timeout: got no ack expected ack at cycle %0d", 2 + LAT_A);
      sbA.delete();
    end
    @(negedge clk);
    total++;
    if (ifAck !== 1'b0 || ifRdata !== 32'h2008_0005) begin
      bad++; $display("[TB] FAIL fetch_pulse_hold: got if_ack=%b if_rdata=%h expected 0 and 20080005", ifAck, ifRdata);
    end
  endtask

  task automatic test_priority();
    exp_t e;
    int c0;
    @(negedge clk);
    c0 = cyc;
    ifReq = 1'b1; ifAddr = 32'h0040_0004;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h1001_0000;
    sbA.push_back(exp_t'{1'b1, 32'hDEAD_BEEF, c0 + 3});
    sbA.push_back(exp_t'{1'b0, 32'h8C09_0000, c0 + 7});
    for (int n = 0; n < 30 && sbA.size() > 0; n++) begin
      @(negedge clk);
      if (ifAck === 1'b1 || dAck === 1'b1) begin
        e = sbA.pop_front();
        total++;
        if (dAck !== e.isData || ifAck === dAck) begin
          bad++; $display("[TB] FAIL prio_owner: got d_ack=%b if_ack=%b expected data=%b", dAck, ifAck, e.isData);
        end
        total++;
        if (cyc != e.ackCyc) begin
          bad++; $display("[TB] FAIL prio_ack_cycle: got %0d expected %0d", cyc - c0, e.ackCyc - c0);
        end
        total++;
        if ((e.isData ? dRdata : ifRdata) !== e.data) begin
          bad++; $display("[TB] FAIL prio_rdata: got %h expected %h", e.isData ? dRdata : ifRdata, e.data);
        end
        if (dAck === 1'b1) dReq = 1'b0;
        if (ifAck === 1'b1) ifReq = 1'b0;
      end
    end
    total++;
    if (sbA.size() != 0) begin
      bad++; $display("[TB] FAIL prio_timeout: got %0d acks outstanding expected 0", sbA.size());
      sbA.delete();
    end
    dReq = 1'b0; ifReq = 1'b0;
  endtask

  task automatic test_starvation();
    exp_t e;
    int c0;
    int k = 0;
    for (int i = 0; i < 5; i++) memArr[32'h1001_0100 + 32'(4 * i)] = 32'hA000_0000 + 32'(i);
    @(negedge clk);
    c0 = cyc;
    ifReq = 1'b1; ifAddr = 32'h0040_0008;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h1001_0100;
    for (int i = 0; i < 4; i++) sbA.push_back(exp_t'{1'b1, 32'hA000_0000 + 32'(i), c0 + 3 + 4 * i});
    sbA.push_back(exp_t'{1'b0, 32'h2409_0007, c0 + 19});
    sbA.push_back(exp_t'{1'b1, 32'hA000_0004, c0 + 23});
    for (int n = 0; n < 60 && sbA.size() > 0; n++) begin
      @(negedge clk);
      if (ifAck === 1'b1 || dAck === 1'b1) begin
        e = sbA.pop_front();
        total++;
        if (dAck !== e.isData || ifAck === dAck) begin
          bad++; $display("[TB] FAIL starve_owner: got d_ack=%b if_ack=%b expected data=%b", dAck, ifAck, e.isData);
        end
        total++;
        if (cyc != e.ackCyc) begin
          bad++; $display("[TB] FAIL starve_ack_cycle: got %0d expected %0d", cyc - c0, e.ackCyc - c0);
        end
        total++;
        if ((e.isData ? dRdata : ifRdata) !== e.data) begin
          bad++; $display("[TB] FAIL starve_rdata: got %h expected %h", e.isData ? dRdata : ifRdata, e.data);
        end
        if (dAck === 1'b1) begin
          k++;
          if (k == 5) dReq = 1'b0;
          else dAddr = 32'h1001_0100 + 32'(4 * k);
        end
        if (ifAck === 1'b1) ifReq = 1'b0;
      end
    end
    total++;
    if (sbA.size() != 0) begin
      bad++; $display("[TB] FAIL starve_timeout: got %0d acks outstanding expected 0", sbA.size());
      sbA.delete();
    end
    dReq = 1'b0; ifReq = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_latency3();
    exp_t e;
    int c0;
    int en0, we0;
    bit seen = 0;
    @(negedge clk);
    en0 = memEnCntB; we0 = memWeCntB;
    c0 = cyc;
    bDReq = 1'b1; bDWe = 1'b1; bDAddr = 32'h1001_0004; bDWdata = 32'h0000_00FF;
    sbB.push_back(exp_t'{1'b1, 32'h0, c0 + 2 + LAT_B});
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bDAck === 1'b1 || bIfAck === 1'b1) begin
        seen = 1;
        e = sbB.pop_front();
        bDReq = 1'b0;
        total++;
        if (cyc != e.ackCyc || bDAck !== 1'b1) begin
          bad++; $display("[TB] FAIL store_ack: got cycle %0d d_ack=%b expected cycle %0d d_ack=1", cyc - c0, bDAck, e.ackCyc - c0);
        end
        total++;
        if (bDRdata !== e.data) begin
          bad++; $display("[TB] FAIL store_rdata_kept: got %h expected %h", bDRdata, e.data);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL store_timeout: got no ack expected ack at cycle %0d", 2 + LAT_B);
      sbB.delete();
    end
    total++;
    if (memEnCntB - en0 != 1 || memWeCntB - we0 != 1) begin
      bad++; $display("[TB] FAIL store_strobe: got en cycles=%0d we cycles=%0d expected 1 and 1", memEnCntB - en0, memWeCntB - we0);
    end
    total++;
    if (readMem(32'h1001_0004) !== 32'h0000_00FF) begin
      bad++; $display("[TB] FAIL store_mem: got %h expected 000000ff", readMem(32'h1001_0004));
    end
    // Follow with a load on the same latency-3 port
    @(negedge clk);
    c0 = cyc; seen = 0;
    bDReq = 1'b1; bDWe = 1'b0; bDAddr = 32'h1001_0000;
    sbB.push_back(exp_t'{1'b1, 32'hDEAD_BEEF, c0 + 2 + LAT_B});
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bDAck === 1'b1 || bIfAck === 1'b1) begin
        seen = 1;
        e = sbB.pop_front();
        bDReq = 1'b0;
        total++;
        if (cyc != e.ackCyc || bDRdata !== e.data) begin
          bad++; $display("[TB] FAIL lat3_load: got cycle %0d data %h expected cycle %0d data %h", cyc - c0, bDRdata, e.ackCyc - c0, e.data);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL lat3_timeout: got no ack expected ack at cycle %0d", 2 + LAT_B);
      sbB.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    int c1;
    bit seen = 0;
    @(negedge clk);
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h1001_0000;
    @(negedge clk);
    total++;
    if (memEn !== 1'b1) begin
      bad++; $display("[TB] FAIL rst_pre_issue: got mem_en=%b expected 1", memEn);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({memEn, memWe, dAck, ifAck} !== 4'b0000) begin
      bad++; $display("[TB] FAIL rst_async_ctrl: got en/we/dack/ifack=%b expected 0000", {memEn, memWe, dAck, ifAck});
    end
    total++;
    if (dRdata !== 32'h0) begin
      bad++; $display("[TB] FAIL rst_async_rdata: got %h expected 00000000", dRdata);
    end
    @(negedge clk);
    reset = 1'b1;
    c1 = cyc;
    sbA.push_back(exp_t'{1'b1, 32'hDEAD_BEEF, c1 + 2 + LAT_A});
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (dAck === 1'b1 || ifAck === 1'b1) begin
        seen = 1;
        e = sbA.pop_front();
        dReq = 1'b0;
        total++;
        if (cyc != e.ackCyc || dAck !== 1'b1) begin
          bad++; $display("[TB] FAIL rst_regrant_cycle: got cycle %0d d_ack=%b expected cycle %0d d_ack=1", cyc - c1, dAck, e.ackCyc - c1);
        end
        total++;
        if (dRdata !== e.data) begin
          bad++; $display("[TB] FAIL rst_regrant_rdata: got %h expected %h", dRdata, e.data);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL rst_regrant_timeout: got no ack expected ack at cycle %0d", 2 + LAT_A);
      sbA.delete();
    end
    @(negedge clk);
  endtask

`ifdef MEM_ARB_IO_PORT_EN
  task automatic test_io_port();
    exp_t e;
    int c0;
    int en0;
    bit seen = 0;
    memArr[32'h1001_0024] = 32'h0000_0055;
    portIn = 8'h03;
    @(negedge clk);
    en0 = memEnCntA;
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h1001_0024; dWdata = 32'h0000_0003;
    @(negedge clk);
    total++;
    if (dAck !== 1'b1 || portOut !== 32'h0000_0003) begin
      bad++; $display("[TB] FAIL io_store: got d_ack=%b port_out=%h expected 1 and 00000003", dAck, portOut);
    end
    dReq = 1'b0;
    repeat (2) @(negedge clk);
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h1001_0028;
    @(negedge clk);
    total++;
    if (dAck !== 1'b1 || dRdata !== 32'h0000_0003) begin
      bad++; $display("[TB] FAIL io_load: got d_ack=%b d_rdata=%h expected 1 and 00000003", dAck, dRdata);
    end
    dReq = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (memEnCntA != en0) begin
      bad++; $display("[TB] FAIL io_no_mem: got %0d mem_en cycles expected 0", memEnCntA - en0);
    end
    // A load from the output-port address is an ordinary memory access
    c0 = cyc;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h1001_0024;
    sbA.push_back(exp_t'{1'b1, 32'h0000_0055, c0 + 2 + LAT_A});
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (dAck === 1'b1 || ifAck === 1'b1) begin
        seen = 1;
        e = sbA.pop_front();
        dReq = 1'b0;
        total++;
        if (cyc != e.ackCyc || dRdata !== e.data) begin
          bad++; $display("[TB] FAIL io_mem_load: got cycle %0d data %h expected cycle %0d data %h", cyc - c0, dRdata, e.ackCyc - c0, e.data);
        end
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("[TB] FAIL io_mem_timeout: got no ack expected ack at cycle %0d", 2 + LAT_A);
      sbA.delete();
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    memArr[32'h0040_0000] = 32'h2008_0005;
    memArr[32'h0040_0004] = 32'h8C09_0000;
    memArr[32'h0040_0008] = 32'h2409_0007;
    memArr[32'h1001_0000] = 32'hDEAD_BEEF;
    memArr[32'h1001_0004] = 32'h1234_5678;
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_store_latency3();
    test_reset_mid_wait();
`ifdef MEM_ARB_IO_PORT_EN
    test_io_port();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported unified instruction/data memory between the processor's fetch stage and its load/store stage. It sits between the MIPS datapath and the memory array and runs a request/acknowledge handshake with each requester. Data accesses have priority, and a starvation counter guarantees fetch progress. An optional memory-mapped I/O decode drives the processor's output port.

## Interface
- ADDR_WIDTH, 32, width of all addresses
- DATA_WIDTH, 32, width of all data buses
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..7
- STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch wins; legal range 1..15
- IO_OUT_ADDR, 32'h1001_0024, output-port address; used only with MEM_ARB_IO_PORT_EN
- IO_IN_ADDR, 32'h1001_0028, input-port address; used only with MEM_ARB_IO_PORT_EN
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_WIDTH  fetch address
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DATA_WIDTH  fetched word; valid while if_ack is high, held afterwards
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DATA_WIDTH  load data; valid while d_ack is high, held afterwards
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data
- port_in  in  8  external input port (present only with MEM_ARB_IO_PORT_EN)
- port_out  out  DATA_WIDTH  output-port register (present only with MEM_ARB_IO_PORT_EN)

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if either request is high, grant one, latch its address, write data and direction, then go to ISSUE. Otherwise stay in IDLE.
- Priority: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - Increments (saturating) at each IDLE grant to data while if_req is high.
  - Clears on a fetch grant or whenever if_req is low in IDLE.
- ISSUE: mem_en = 1 for exactly one cycle; mem_we/mem_addr/mem_wdata come from the latched request. Go to WAIT with lat_cnt = 0.
- WAIT: increments lat_cnt. When lat_cnt == MEM_LATENCY-1, capture mem_rdata into the granted requester's rdata register (loads and fetches only) and go to RESP.
- RESP: the granted requester's ack = 1 for one cycle, then go to IDLE.
- A request asserted during ISSUE/WAIT/RESP is considered only in the next IDLE.
- Stores also receive an ack. rdata is not updated on stores.
- Requester inputs may change after ack. The arbiter never reads them outside IDLE.

## Timing
- Reset (asynchronous, immediate): state = IDLE, starve_cnt = 0, and every output is 0, including rdata registers and port_out.
- Reset mid-transaction aborts it:
  - mem_en drops at once and no ack is produced.
  - Requests still high after release are re-arbitrated from IDLE.
- Cycle numbering: request high in cycle 0 (IDLE).
  - mem_en in cycle 1.
  - mem_rdata valid in cycle 1+MEM_LATENCY.
  - ack in cycle 2+MEM_LATENCY.
  - IDLE in cycle 3+MEM_LATENCY.
- Back-to-back transactions start every MEM_LATENCY+3 cycles.
- All outputs are registered. There is no combinational path from a request input to any output.

## Configuration
- MEM_ARB_IO_PORT_EN defined:
  - A data access whose d_addr equals IO_OUT_ADDR (store) or IO_IN_ADDR (load) bypasses memory.
  - The arbiter goes IDLE to RESP directly and mem_en stays 0.
  - A store writes d_wdata to port_out at the grant edge.
  - A load returns {24'b0, port_in} in d_rdata.
  - d_ack appears in cycle 1.
  - A load from IO_OUT_ADDR or a store to IO_IN_ADDR goes to memory normally.
- MEM_ARB_IO_PORT_EN undefined: port_in/port_out are absent and all addresses go to memory.

## Structure
- Shared package mem_arb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - a grant-owner enum (GNT_IF/GNT_D);
  - the default IO_OUT_ADDR/IO_IN_ADDR constants.
- One sub-module, arb_starve_counter: the saturating starvation counter with an at_limit output.

## Test plan
- Single fetch, MEM_LATENCY=1: if_req with if_addr=0x0040_0000, memory returns 0x2008_0005 -> mem_en in cycle 1, if_ack in cycle 3, if_rdata=0x2008_0005.
- Simultaneous if_req and d_req (load 0x1001_0000, data 0xDEAD_BEEF) -> data granted first, d_ack in cycle 3; fetch then granted, if_ack in cycle 7.
- d_req held continuously with if_req high, STARVE_LIMIT=4 -> four data grants, then the fifth grant goes to fetch and starve_cnt returns to 0.
- MEM_LATENCY=3, store 0x0000_00FF to 0x1001_0004 -> mem_en=1 and mem_we=1 for one cycle, d_ack in cycle 5, d_rdata unchanged.
- Reset pulled low during WAIT -> mem_en and all acks 0 immediately, no ack after release, pending d_req re-granted from IDLE.
- With MEM_ARB_IO_PORT_EN: store 0x0000_0003 to 0x1001_0024 -> port_out=3, d_ack in cycle 1, mem_en never high. Load from 0x1001_0028 with port_in=3 -> d_rdata=0x0000_0003.
